// File: rtl/debounce_delay_timer_pkg.sv
// Shared encodings and default sizing for the debouncer delay timer.
// Used by the timer, its interface and the control FSM / top level.
package debounce_delay_timer_pkg;

    localparam int unsigned CntWDefault     = 16;
    localparam int unsigned PrescaleDefault = 1000;
    localparam int unsigned PreWDefault     = 10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/debounce_delay_timer_if.sv
// Handshake bundle between the debouncer control FSM (master) and the delay timer (slave).
interface debounce_delay_timer_if
    import debounce_delay_timer_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) ();

    logic             clr;
    logic [CNT_W-1:0] delay_cycles;
    logic             end_delay;
    logic             busy;
    logic [CNT_W-1:0] cnt_dbg;

    modport master (
        output clr,
        output delay_cycles,
        input  end_delay,
        input  busy,
        input  cnt_dbg
    );

    modport slave (
        input  clr,
        input  delay_cycles,
        output end_delay,
        output busy,
        output cnt_dbg
    );

endinterface

// File: rtl/debounce_tick_gen.sv
// Prescaler for the delay timer: one tick every PRESCALE enabled clocks.
// Only instantiated when DEBOUNCE_PRESCALE_EN is defined.
module debounce_tick_gen #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned PRE_W    = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam logic [PRE_W-1:0] PreMax = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign tick = enable && !restart && (pre_q == PreMax);

    always_comb begin
        pre_d = pre_q;
        if (restart) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = (pre_q == PreMax) ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/debounce_delay_timer.sv
// Programmable settle-delay timer feeding end_delay to the debouncer control FSM.
// Define DEBOUNCE_PRESCALE_EN to stretch each count unit to PRESCALE clocks.
module debounce_delay_timer
    import debounce_delay_timer_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDefault,
    parameter int unsigned PRESCALE = PrescaleDefault,
    parameter int unsigned PRE_W    = PreWDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    debounce_delay_timer_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             end_delay_q, end_delay_d;
    logic             busy_q, busy_d;
    logic             tick;

`ifdef DEBOUNCE_PRESCALE_EN
    debounce_tick_gen #(
        .PRESCALE(PRESCALE),
        .PRE_W   (PRE_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == StRun),
        .restart((state_q != StRun) || bus.clr),
        .tick   (tick)
    );
`else
    logic unused_prescale_cfg;
    assign unused_prescale_cfg = ^{PRESCALE, PRE_W};
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!bus.clr) begin
                    // A zero delay behaves like one count unit.
                    target_d = (bus.delay_cycles == '0) ? CNT_W'(1) : bus.delay_cycles;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (bus.clr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == target_q - CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.clr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        end_delay_d = (state_d == StDone);
        busy_d      = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            target_q    <= '0;
            end_delay_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            end_delay_q <= end_delay_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.end_delay = end_delay_q;
    assign bus.busy      = busy_q;
    assign bus.cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_debounce_delay_timer.sv
// Self-checking bench for debounce_delay_timer: directed literal checks plus randomized
// clr/delay/rst traffic compared every cycle against an elapsed-time model.
module tb_debounce_delay_timer;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PRE   = 4;
    localparam int unsigned PRE_W = 3;
`ifdef DEBOUNCE_PRESCALE_EN
    localparam int F = PRE;
`else
    localparam int F = 1;
`endif

    logic clk = 1'b0;
    logic rst;

    debounce_delay_timer_if #(.CNT_W(CNT_W)) bus ();

    debounce_delay_timer #(
        .CNT_W   (CNT_W),
        .PRESCALE(PRE),
        .PRE_W   (PRE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // Model: the timer is "started" from the edge clr is first seen low, and the outputs
    // follow from clocks elapsed since then versus target * F.
    bit m_started = 1'b0;
    int m_elapsed = 0;
    int m_tgt     = 1;

    always @(posedge clk) begin
        if (!rst || bus.clr) begin
            m_started = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_elapsed = 0;
            m_tgt     = (bus.delay_cycles == '0) ? 1 : int'(bus.delay_cycles);
        end else if (m_elapsed < m_tgt * F) begin
            m_elapsed++;
        end
    end

    function automatic int exp_end();
        return int'(m_started && (m_elapsed >= m_tgt * F));
    endfunction

    function automatic int exp_busy();
        return int'(m_started && (m_elapsed < m_tgt * F));
    endfunction

    function automatic int exp_cnt();
        return m_started ? (m_elapsed / F) : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model_end_delay", int'(bus.end_delay), exp_end());
            check("model_busy", int'(bus.busy), exp_busy());
            check("model_cnt_dbg", int'(bus.cnt_dbg), exp_cnt());
        end
    end

    initial begin
        int hold;
        rst              = 1'b0;
        bus.clr          = 1'b1;
        bus.delay_cycles = '0;
        repeat (2) @(negedge clk);
        check("reset_end_delay", int'(bus.end_delay), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_cnt", int'(bus.cnt_dbg), 0);
        check_en = 1'b1;
        rst      = 1'b1;
        repeat (3) @(negedge clk);

        // delay 5: busy after E0, cnt 1 after E0+F, end_delay after E0+5F
        bus.delay_cycles = CNT_W'(5);
        bus.clr          = 1'b0;
        @(negedge clk);
        check("d5_busy_after_e0", int'(bus.busy), 1);
        check("d5_end_after_e0", int'(bus.end_delay), 0);
        repeat (F) @(negedge clk);
        check("d5_cnt_one_unit", int'(bus.cnt_dbg), 1);
        repeat (4 * F - 1) @(negedge clk);
        check("d5_end_not_early", int'(bus.end_delay), 0);
        @(negedge clk);
        check("d5_end_rise", int'(bus.end_delay), 1);
        check("d5_busy_done", int'(bus.busy), 0);
        check("d5_cnt_done", int'(bus.cnt_dbg), 5);
        bus.delay_cycles = CNT_W'(9);
        repeat (3) @(negedge clk);
        check("d5_end_hold", int'(bus.end_delay), 1);
        bus.clr = 1'b1;
        @(negedge clk);
        check("d5_end_fall", int'(bus.end_delay), 0);
        check("d5_cnt_clear", int'(bus.cnt_dbg), 0);

        // delay 0 behaves as 1
        bus.delay_cycles = '0;
        bus.clr          = 1'b0;
        @(negedge clk);
        repeat (F - 1) @(negedge clk);
        check("d0_end_not_early", int'(bus.end_delay), 0);
        @(negedge clk);
        check("d0_end_rise", int'(bus.end_delay), 1);
        check("d0_cnt", int'(bus.cnt_dbg), 1);
        bus.clr = 1'b1;
        @(negedge clk);

        // one-cycle clr pulse mid-run restarts from 0
        bus.delay_cycles = CNT_W'(10);
        bus.clr          = 1'b0;
        @(negedge clk);
        repeat (6 * F - 1) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        check("abort_busy_drop", int'(bus.busy), 0);
        bus.clr = 1'b0;
        @(negedge clk);
        repeat (10 * F - 1) @(negedge clk);
        check("abort_no_early", int'(bus.end_delay), 0);
        @(negedge clk);
        check("abort_end_rise", int'(bus.end_delay), 1);
        bus.clr = 1'b1;
        @(negedge clk);

        // reset during DONE
        bus.delay_cycles = CNT_W'(2);
        bus.clr          = 1'b0;
        repeat (2 * F + 2) @(negedge clk);
        check("rstdone_pre_end", int'(bus.end_delay), 1);
        rst     = 1'b0;
        bus.clr = 1'b1;
        @(negedge clk);
        check("rstdone_end", int'(bus.end_delay), 0);
        check("rstdone_busy", int'(bus.busy), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rstdone_idle_busy", int'(bus.busy), 0);
        check("rstdone_idle_cnt", int'(bus.cnt_dbg), 0);

        // maximum target, no wrap
        bus.delay_cycles = '1;
        bus.clr          = 1'b0;
        @(negedge clk);
        repeat (255 * F - 1) @(negedge clk);
        check("max_end_not_early", int'(bus.end_delay), 0);
        check("max_cnt_254", int'(bus.cnt_dbg), 254);
        @(negedge clk);
        check("max_end_rise", int'(bus.end_delay), 1);
        check("max_cnt_255", int'(bus.cnt_dbg), 255);
        bus.clr = 1'b1;
        @(negedge clk);

        // randomized traffic; delay_cycles churns every cycle and must be ignored mid-run
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) != 0);
            if (hold == 0) begin
                bus.clr = ($urandom_range(0, 2) == 0);
                hold    = bus.clr ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 60));
            end
            hold--;
            if ($urandom_range(0, 9) == 0) begin
                bus.delay_cycles = CNT_W'($urandom_range(0, 40));
            end else begin
                bus.delay_cycles = CNT_W'($urandom_range(0, 12));
            end
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
